// File: rtl/fread_arbiter_if.sv
// rtl/fread_arbiter_if.sv - client and upstream fread signal bundle for fread_arbiter
//
// Client side (N_CLIENTS requesters):
//   cli_req_valid/offset/len  request from each client, fields packed per client
//   cli_req_ready             one-hot accept
//   cli_resp_data             response byte, broadcast
//   cli_resp_valid            one-hot owner of cli_resp_data
//   cli_done                  one-hot completion pulse
// Upstream side (single fread core):
//   req_valid/req_ready/req_offset  request handshake
//   resp_data/resp_valid            response byte strobe
// Status: busy, grant_id, err_stray
// Modport master is the arbiter; modport slave is the surrounding environment.
interface fread_arbiter_if #(
  parameter int N_CLIENTS = 2,
  parameter int LEN_W     = 16
);
  logic [N_CLIENTS-1:0]       cli_req_valid;
  logic [32*N_CLIENTS-1:0]    cli_req_offset;
  logic [LEN_W*N_CLIENTS-1:0] cli_req_len;
  logic [N_CLIENTS-1:0]       cli_req_ready;
  logic [7:0]                 cli_resp_data;
  logic [N_CLIENTS-1:0]       cli_resp_valid;
  logic [N_CLIENTS-1:0]       cli_done;
  logic                       req_valid;
  logic                       req_ready;
  logic [31:0]                req_offset;
  logic [7:0]                 resp_data;
  logic                       resp_valid;
  logic                       busy;
  logic [2:0]                 grant_id;
  logic                       err_stray;

  modport master (
    input  cli_req_valid, cli_req_offset, cli_req_len, req_ready, resp_data, resp_valid,
    output cli_req_ready, cli_resp_data, cli_resp_valid, cli_done,
           req_valid, req_offset, busy, grant_id, err_stray
  );

  modport slave (
    output cli_req_valid, cli_req_offset, cli_req_len, req_ready, resp_data, resp_valid,
    input  cli_req_ready, cli_resp_data, cli_resp_valid, cli_done,
           req_valid, req_offset, busy, grant_id, err_stray
  );
endinterface

// File: rtl/fread_arbiter.sv
// rtl/fread_arbiter.sv - round-robin sharing of one fread port between N_CLIENTS loaders
//
// Ports:
//   clk  clock
//   rst  synchronous reset, active-high
//   bus  fread_arbiter_if.master (client requests/responses, upstream fread, status)
// A granted client's (offset, len) is latched, issued upstream, and the next len
// response bytes are steered to that client only, ending with a cli_done pulse.
module fread_arbiter #(
  parameter int N_CLIENTS = 2,
  parameter int LEN_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  fread_arbiter_if.master  bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_STREAM} state_t;

  localparam logic [N_CLIENTS-1:0] ONE = N_CLIENTS'(1);

  state_t           state, state_next;
  logic [2:0]       rr_ptr;
  logic [31:0]      off_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic [2:0]       pick;
  logic             pick_found;
  logic [31:0]      pick_off;
  logic [LEN_W-1:0] pick_len;
  logic             accept;
  logic             last_byte;
  int               cand;

  // Round-robin search: walk candidates starting at rr_ptr, wrapping modulo N_CLIENTS.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    pick_off   = '0;
    pick_len   = '0;
    cand       = 0;
    for (int k = 0; k < N_CLIENTS; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= N_CLIENTS) cand = cand - N_CLIENTS;
      for (int i = 0; i < N_CLIENTS; i++) begin
        if (!pick_found && cand == i && bus.cli_req_valid[i]) begin
          pick       = 3'(i);
          pick_found = 1'b1;
        end
      end
    end
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (pick == 3'(i)) begin
        pick_off = bus.cli_req_offset[32*i +: 32];
        pick_len = bus.cli_req_len[LEN_W*i +: LEN_W];
      end
    end
  end

  // len_q >= 1 whenever STREAM is entered, so len_q - 1 never wraps.
  assign last_byte      = (cnt == len_q - 1'b1);
  assign bus.req_offset = off_q;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next        = state;
    accept            = 1'b0;
    bus.cli_req_ready = '0;
    bus.req_valid     = 1'b0;
    bus.busy          = 1'b0;
    case (state)
      S_IDLE: begin
        // Ready is held off during reset so nothing looks accepted in a cycle that aborts.
        if (pick_found && !rst) begin
          accept = 1'b1;
          for (int i = 0; i < N_CLIENTS; i++) begin
            if (pick == 3'(i)) bus.cli_req_ready[i] = 1'b1;
          end
          if (pick_len != '0) state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        bus.req_valid = 1'b1;
        bus.busy      = 1'b1;
        if (bus.req_ready) state_next = S_STREAM;
      end
      S_STREAM: begin
        bus.busy = 1'b1;
        if (bus.resp_valid && last_byte) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr             <= '0;
      off_q              <= '0;
      len_q              <= '0;
      cnt                <= '0;
      bus.grant_id       <= '0;
      bus.cli_resp_data  <= '0;
      bus.cli_resp_valid <= '0;
      bus.cli_done       <= '0;
      bus.err_stray      <= 1'b0;
    end else begin
      bus.cli_resp_valid <= '0;
      bus.cli_done       <= '0;
      if (accept) begin
        off_q        <= pick_off;
        len_q        <= pick_len;
        bus.grant_id <= pick;
        rr_ptr       <= (pick == 3'(N_CLIENTS - 1)) ? 3'd0 : pick + 3'd1;
        // Zero-length request completes immediately without touching upstream.
        if (pick_len == '0) bus.cli_done <= ONE << pick;
      end
      if (state == S_ISSUE && bus.req_ready) cnt <= '0;
      if (bus.resp_valid) begin
        if (state == S_STREAM) begin
          bus.cli_resp_data  <= bus.resp_data;
          bus.cli_resp_valid <= ONE << bus.grant_id;
          cnt                <= cnt + 1'b1;
          if (last_byte) bus.cli_done <= ONE << bus.grant_id;
        end else begin
          bus.err_stray <= 1'b1;
        end
      end
    end
  end

endmodule
